// File: rtl/divu_seq_ctrl.sv
// rtl/divu_seq_ctrl.sv - multi-cycle sequencer for the unsigned 32-bit restoring divider
// Optional early completion of trivial operands is enabled by defining DIVU_FAST_PATH_EN.

module divu_1iter (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [31:0] remainder,
    input  logic [31:0] quotient,
    output logic [31:0] dividend_nxt,
    output logic [31:0] remainder_nxt,
    output logic [31:0] quotient_nxt
);
    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;

    always_comb begin
        // 33 bits so a remainder with bit 31 set is not lost before the compare
        trial         = {remainder, dividend[31]};
        diff          = trial - {1'b0, divisor};
        ge            = (trial >= {1'b0, divisor});
        remainder_nxt = ge ? diff[31:0] : trial[31:0];
        quotient_nxt  = {quotient[30:0], ge};
        dividend_nxt  = {dividend[30:0], 1'b0};
    end
endmodule

module divu_seq_ctrl #(
    parameter int ITERS_PER_CYCLE = 1,
    parameter int WIDTH           = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy
);
    localparam int N_CYC = 32 / ITERS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] dvd_q, dvs_q, rem_q, quo_q;
    logic [4:0]  cnt_q;
    logic        accept, finish, fast;
    logic [31:0] fast_q, fast_r;

    logic [31:0] dvd_c [0:ITERS_PER_CYCLE];
    logic [31:0] rem_c [0:ITERS_PER_CYCLE];
    logic [31:0] quo_c [0:ITERS_PER_CYCLE];

    assign dvd_c[0] = dvd_q;
    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < ITERS_PER_CYCLE; g++) begin : g_iter
        divu_1iter u_iter (
            .dividend     (dvd_c[g]),
            .divisor      (dvs_q),
            .remainder    (rem_c[g]),
            .quotient     (quo_c[g]),
            .dividend_nxt (dvd_c[g+1]),
            .remainder_nxt(rem_c[g+1]),
            .quotient_nxt (quo_c[g+1])
        );
    end

`ifdef DIVU_FAST_PATH_EN
    always_comb begin
        fast   = 1'b1;
        fast_q = 32'h0;
        fast_r = i_dividend;
        if (i_divisor == 32'h0) begin
            fast_q = 32'hFFFF_FFFF;
        end else if (i_divisor == 32'h1) begin
            fast_q = i_dividend;
            fast_r = 32'h0;
        end else if (i_divisor <= i_dividend) begin
            fast = 1'b0;
        end
    end
`else
    assign fast   = 1'b0;
    assign fast_q = 32'h0;
    assign fast_r = 32'h0;
`endif

    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q == BUSY);
    assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    accept  = 1'b1;
                    state_d = fast ? DONE : BUSY;
                end
                BUSY: if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
                DONE: if (i_ready) begin
                    if (i_valid) begin
                        accept  = 1'b1;
                        state_d = fast ? DONE : BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= 32'h0;
            dvs_q       <= 32'h0;
            rem_q       <= 32'h0;
            quo_q       <= 32'h0;
            cnt_q       <= 5'd0;
            o_quotient  <= 32'h0;
            o_remainder <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dvd_q <= i_dividend;
                dvs_q <= i_divisor;
                rem_q <= 32'h0;
                quo_q <= 32'h0;
                cnt_q <= 5'd0;
                if (fast) begin
                    o_quotient  <= fast_q;
                    o_remainder <= fast_r;
                end
            end else if (state_q == BUSY && !i_flush) begin
                dvd_q <= dvd_c[ITERS_PER_CYCLE];
                rem_q <= rem_c[ITERS_PER_CYCLE];
                quo_q <= quo_c[ITERS_PER_CYCLE];
                cnt_q <= cnt_q + 5'd1;
                // Outputs only ever see a finished result, never partial state
                if (finish) begin
                    o_quotient  <= quo_c[ITERS_PER_CYCLE];
                    o_remainder <= rem_c[ITERS_PER_CYCLE];
                end
            end
        end
    end
endmodule

// File: tb/tb_divu_seq_ctrl.sv
// tb/tb_divu_seq_ctrl.sv - directed and random self-checking bench for divu_seq_ctrl

module tb_divu_seq_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_dividend = 32'h0;
    logic [31:0] i_divisor = 32'h0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIVU_FAST_PATH_EN
    localparam int FAST_LAT = 0;
`else
    localparam int FAST_LAT = 32;
`endif

    always #5 i_clk = ~i_clk;

    divu_seq_ctrl dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_busy     (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request; returns #1 after the accept edge with i_valid dropped
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Edges from the accept edge until o_valid is seen, bounded at 100
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat);
        int lat;
        start(a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, o_quotient, eq);
        check({tag, "_r"}, o_remainder, er);
    endtask

    initial begin
        int lat;
        logic [31:0] a, b, eq, er;
        bit seen;

        #23;
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_q", o_quotient, 32'h0);
        check("rst_r", o_remainder, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("rst_ready", {31'h0, o_ready}, 32'h1);

        run_op("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 32);
        @(posedge i_clk);
        #1;
        check("t1_taken_valid", {31'h0, o_valid}, 32'h0);
        check("t1_idle_ready", {31'h0, o_ready}, 32'h1);

        // Back-to-back: i_valid held high through BUSY and DONE with the second operands
        @(negedge i_clk);
        i_dividend = 32'h8000_0000;
        i_divisor  = 32'd2;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_divisor = 32'd1;
        check("t2_busy_noready", {31'h0, o_ready}, 32'h0);
        wait_valid(lat);
        check("t2a_lat", 32'(lat), 32'd32);
        check("t2a_q", o_quotient, 32'h4000_0000);
        check("t2a_r", o_remainder, 32'h0);
        check("t2a_ready", {31'h0, o_ready}, 32'h1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
`ifdef DIVU_FAST_PATH_EN
        lat = 0;
`else
        check("t2b_busy", {31'h0, o_busy}, 32'h1);
        wait_valid(lat);
`endif
        check("t2b_lat", 32'(lat), 32'(FAST_LAT));
        check("t2b_q", o_quotient, 32'h8000_0000);
        check("t2b_r", o_remainder, 32'h0);
        @(posedge i_clk);
        #1;

        run_op("t3_div0", 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, FAST_LAT);
        @(posedge i_clk);
        #1;

        // Consumer stall in DONE
        i_ready = 1'b0;
        run_op("t4_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 32);
        repeat (10) @(posedge i_clk);
        #1;
        check("t4_hold_valid", {31'h0, o_valid}, 32'h1);
        check("t4_hold_q", o_quotient, 32'd333);
        check("t4_hold_r", o_remainder, 32'd1);
        check("t4_hold_ready", {31'h0, o_ready}, 32'h0);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("t4_release", {31'h0, o_valid}, 32'h0);

        // Flush mid-BUSY, with a request presented on the flush edge that must be dropped
        start(32'd1000, 32'd7);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush    = 1'b1;
        i_valid    = 1'b1;
        i_dividend = 32'd77;
        i_divisor  = 32'd4;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("t5_flush_busy", {31'h0, o_busy}, 32'h0);
        check("t5_flush_ready", {31'h0, o_ready}, 32'h1);
        check("t5_flush_q", o_quotient, 32'd333);
        check("t5_flush_r", o_remainder, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_valid || o_busy) seen = 1'b1;
        end
        check("t5_no_result", {31'h0, seen}, 32'h0);
        run_op("t5_50_5", 32'd50, 32'd5, 32'd10, 32'd0, 32);
        @(posedge i_clk);
        #1;

        // Asynchronous reset in the middle of an operation
        start(32'd12345, 32'd17);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("t5_arst_busy", {31'h0, o_busy}, 32'h0);
        check("t5_arst_valid", {31'h0, o_valid}, 32'h0);
        check("t5_arst_q", o_quotient, 32'h0);
        check("t5_arst_r", o_remainder, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        check("t5_arst_no_result", {31'h0, seen}, 32'h0);

        // Random operands against the language's own / and %
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = b >> ($urandom % 32);
            if (i % 17 == 0) b = 32'h0;
            if (i % 19 == 0) b = 32'h1;
            if (b == 32'h0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            start(a, b);
            wait_valid(lat);
`ifdef DIVU_FAST_PATH_EN
            if (b > 1 && b <= a) check("rnd_lat", 32'(lat), 32'd32);
            else check("rnd_lat", 32'(lat), 32'd0);
`else
            check("rnd_lat", 32'(lat), 32'd32);
`endif
            check("rnd_q", o_quotient, eq);
            check("rnd_r", o_remainder, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
